// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared FSM encoding and stage-control bundle layout for the pipeline hazard controller
package pipe_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    // Stage-control bundle bit positions, MSB first: {PC, IFID, IDEX, EXMEM, MEMWB}.
    // The PC has only an enable, so clear vectors stop at STG_IFID.
    localparam int STG_N     = 5;
    localparam int STG_PC    = 4;
    localparam int STG_IFID  = 3;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 1;
    localparam int STG_MEMWB = 0;

    typedef logic [STG_N-1:0] stage_en_t;
    typedef logic [STG_N-2:0] stage_clr_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator between the ID and EX stages
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_W = pipe_pkg::REG_W
) (
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic             EX_ReadMem,
    input  logic             EX_WriteReg,
    output logic             LoadUse
);

    logic ex_loads_reg;
    logic rs_hit;
    logic rt_hit;

    // $zero is never a real dependency, so a load targeting it never stalls.
    assign ex_loads_reg = EX_ReadMem && EX_WriteReg && (EX_Rt != '0);
    assign rs_hit       = (EX_Rt == ID_Rs);
    assign rt_hit       = ID_UsesRt && (EX_Rt == ID_Rt);
    assign LoadUse      = ex_loads_reg && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush FSM with memory-wait timeout trap and saturating stall counter
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_W       = pipe_pkg::REG_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic             EX_ReadMem,
    input  logic             EX_WriteReg,
    input  logic             MEM_Branch,
    input  logic             MEM_Zero,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    output logic             PC_En,
    output logic             IFID_En,
    output logic             IFID_Clr,
    output logic             IDEX_En,
    output logic             IDEX_Clr,
    output logic             EXMEM_En,
    output logic             EXMEM_Clr,
    output logic             MEMWB_En,
    output logic             MEMWB_Clr,
    output logic             Trap,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

    state_t          state;
    state_t          next_state;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] next_to;
    logic            set_trap;
    logic            load_use;
    logic            mem_stall;
    logic            br_taken;
    logic            stall_evt;
    stage_en_t       en;
    stage_clr_t      clr;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_detect (
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UsesRt   (ID_UsesRt),
        .EX_Rt       (EX_Rt),
        .EX_ReadMem  (EX_ReadMem),
        .EX_WriteReg (EX_WriteReg),
        .LoadUse     (load_use)
    );

    assign mem_stall = MEM_Req && !MEM_Ready;
    assign br_taken  = MEM_Branch && MEM_Zero;

    always_comb begin
        next_state = state;
        next_to    = to_cnt;
        set_trap   = 1'b0;
        en         = '0;
        clr        = '0;
        unique case (state)
            INIT: begin
                en          = '1;
                en[STG_PC]  = 1'b0;
                clr         = '1;
                next_state  = RUN;
            end
            RUN: begin
                if (mem_stall) begin
                    // Freeze everything upstream of MEM; MEM/WB takes a bubble.
                    en[STG_MEMWB]  = 1'b1;
                    clr[STG_MEMWB] = 1'b1;
                    next_to        = TO_ONE;
                    if (TO_ONE >= TO_LIM) begin
                        next_state = HALT;
                        set_trap   = 1'b1;
                    end else begin
                        next_state = MEM_WAIT;
                    end
                end else if (br_taken) begin
                    en              = '1;
                    clr[STG_IFID]   = 1'b1;
                    clr[STG_IDEX]   = 1'b1;
                    clr[STG_EXMEM]  = 1'b1;
                end else if (load_use) begin
                    en             = '1;
                    en[STG_PC]     = 1'b0;
                    en[STG_IFID]   = 1'b0;
                    clr[STG_IDEX]  = 1'b1;
                end else begin
                    en = '1;
                end
            end
            MEM_WAIT: begin
                if (MEM_Ready) begin
                    // Release cycle: branch/load-use are re-evaluated once back in RUN.
                    en         = '1;
                    next_state = RUN;
                end else begin
                    en[STG_MEMWB]  = 1'b1;
                    clr[STG_MEMWB] = 1'b1;
                    next_to        = to_cnt + TO_ONE;
                    if (next_to >= TO_LIM) begin
                        next_state = HALT;
                        set_trap   = 1'b1;
                    end
                end
            end
            HALT: begin
                en  = '0;
                clr = '0;
            end
            default: begin
                next_state = INIT;
            end
        endcase
        if (!rst) begin
            en  = '0;
            clr = '1;
        end
    end

    assign PC_En     = en[STG_PC];
    assign IFID_En   = en[STG_IFID];
    assign IDEX_En   = en[STG_IDEX];
    assign EXMEM_En  = en[STG_EXMEM];
    assign MEMWB_En  = en[STG_MEMWB];
    assign IFID_Clr  = clr[STG_IFID];
    assign IDEX_Clr  = clr[STG_IDEX];
    assign EXMEM_Clr = clr[STG_EXMEM];
    assign MEMWB_Clr = clr[STG_MEMWB];

    assign stall_evt = !en[STG_PC] && ((state == RUN) || (state == MEM_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            to_cnt   <= '0;
            Trap     <= 1'b0;
            StallCnt <= '0;
        end else begin
            state  <= next_state;
            to_cnt <= next_to;
            if (set_trap) begin
                Trap <= 1'b1;
            end
            if (stall_evt && (StallCnt != '1)) begin
                StallCnt <= StallCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    // Control word order: {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, EXMEM_En, EXMEM_Clr, MEMWB_En, MEMWB_Clr}
    localparam logic [8:0] C_RST  = 9'b001010101;
    localparam logic [8:0] C_INIT = 9'b011111111;
    localparam logic [8:0] C_NORM = 9'b110101010;
    localparam logic [8:0] C_WAIT = 9'b000000011;
    localparam logic [8:0] C_BR   = 9'b111111110;
    localparam logic [8:0] C_LU   = 9'b000111010;
    localparam logic [8:0] C_HALT = 9'b000000000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       ID_Rs, ID_Rt, EX_Rt;
    logic             ID_UsesRt, EX_ReadMem, EX_WriteReg;
    logic             MEM_Branch, MEM_Zero, MEM_Req, MEM_Ready;
    logic             PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr;
    logic             EXMEM_En, EXMEM_Clr, MEMWB_En, MEMWB_Clr, Trap;
    logic [CNT_W-1:0] StallCnt;
    logic [8:0]       ctl;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(
        .REG_W       (5),
        .MEM_TIMEOUT (4),
        .TO_W        (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ID_Rs       (ID_Rs),
        .ID_Rt       (ID_Rt),
        .ID_UsesRt   (ID_UsesRt),
        .EX_Rt       (EX_Rt),
        .EX_ReadMem  (EX_ReadMem),
        .EX_WriteReg (EX_WriteReg),
        .MEM_Branch  (MEM_Branch),
        .MEM_Zero    (MEM_Zero),
        .MEM_Req     (MEM_Req),
        .MEM_Ready   (MEM_Ready),
        .PC_En       (PC_En),
        .IFID_En     (IFID_En),
        .IFID_Clr    (IFID_Clr),
        .IDEX_En     (IDEX_En),
        .IDEX_Clr    (IDEX_Clr),
        .EXMEM_En    (EXMEM_En),
        .EXMEM_Clr   (EXMEM_Clr),
        .MEMWB_En    (MEMWB_En),
        .MEMWB_Clr   (MEMWB_Clr),
        .Trap        (Trap),
        .StallCnt    (StallCnt)
    );

    assign ctl = {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, EXMEM_En, EXMEM_Clr, MEMWB_En, MEMWB_Clr};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_Rs = '0; ID_Rt = '0; EX_Rt = '0;
        ID_UsesRt = 0; EX_ReadMem = 0; EX_WriteReg = 0;
        MEM_Branch = 0; MEM_Zero = 0; MEM_Req = 0; MEM_Ready = 0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        #1 check_eq({tag, "_init"}, 32'(ctl), 32'(C_INIT));
        cyc();
    endtask

    task automatic set_lu(input logic [4:0] rt);
        EX_ReadMem = 1; EX_WriteReg = 1; EX_Rt = rt; ID_Rs = rt;
    endtask

    initial begin
        idle_inputs();
        #3;
        check_eq("rst_ctl", 32'(ctl), 32'(C_RST));
        check_eq("rst_cnt", 32'(StallCnt), 0);
        check_eq("rst_trap", 32'(Trap), 0);

        do_reset("boot");
        #1 check_eq("run_ctl", 32'(ctl), 32'(C_NORM));
        check_eq("run_cnt", 32'(StallCnt), 0);
        check_eq("run_trap", 32'(Trap), 0);

        // Load-use on rs
        set_lu(5'd8);
        #1 check_eq("lu_rs_ctl", 32'(ctl), 32'(C_LU));
        cyc(); idle_inputs();
        #1 check_eq("lu_rs_after", 32'(ctl), 32'(C_NORM));
        check_eq("lu_rs_cnt", 32'(StallCnt), 1);

        // Load into $zero never stalls
        set_lu(5'd0);
        #1 check_eq("lu_zero_ctl", 32'(ctl), 32'(C_NORM));
        cyc(); idle_inputs();
        check_eq("lu_zero_cnt", 32'(StallCnt), 1);

        // Load-use on rt, gated by ID_UsesRt
        EX_ReadMem = 1; EX_WriteReg = 1; EX_Rt = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd3; ID_UsesRt = 1;
        #1 check_eq("lu_rt_ctl", 32'(ctl), 32'(C_LU));
        ID_UsesRt = 0;
        #1 check_eq("lu_rt_unused", 32'(ctl), 32'(C_NORM));
        ID_UsesRt = 1;
        cyc(); idle_inputs();
        check_eq("lu_rt_cnt", 32'(StallCnt), 2);

        // Non-writing load does not stall
        set_lu(5'd7); EX_WriteReg = 0;
        #1 check_eq("lu_nowr_ctl", 32'(ctl), 32'(C_NORM));
        idle_inputs();

        // Taken branch beats load-use
        set_lu(5'd8); MEM_Branch = 1; MEM_Zero = 1;
        #1 check_eq("br_ctl", 32'(ctl), 32'(C_BR));
        cyc(); idle_inputs();
        check_eq("br_cnt", 32'(StallCnt), 2);
        MEM_Branch = 1; MEM_Zero = 0;
        #1 check_eq("br_nottaken", 32'(ctl), 32'(C_NORM));
        idle_inputs();

        // Memory wait: 3 frozen cycles, then release
        do_reset("mw");
        MEM_Req = 1; MEM_Ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("mw_frz%0d", i), 32'(ctl), 32'(C_WAIT));
            cyc();
        end
        MEM_Ready = 1; set_lu(5'd8); MEM_Branch = 1; MEM_Zero = 1;
        #1 check_eq("mw_release", 32'(ctl), 32'(C_NORM));
        cyc(); idle_inputs();
        #1 check_eq("mw_back_run", 32'(ctl), 32'(C_NORM));
        check_eq("mw_cnt", 32'(StallCnt), 3);
        check_eq("mw_trap", 32'(Trap), 0);

        // Timeout: 4 wait cycles then sticky HALT
        do_reset("to");
        MEM_Req = 1; MEM_Ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("to_wait%0d", i), 32'(ctl), 32'(C_WAIT));
            check_eq($sformatf("to_trap_pre%0d", i), 32'(Trap), 0);
            cyc();
        end
        #1 check_eq("halt_ctl", 32'(ctl), 32'(C_HALT));
        check_eq("halt_trap", 32'(Trap), 1);
        check_eq("halt_cnt", 32'(StallCnt), 4);
        MEM_Ready = 1;
        cyc(); cyc();
        check_eq("halt_sticky_ctl", 32'(ctl), 32'(C_HALT));
        check_eq("halt_sticky_trap", 32'(Trap), 1);
        check_eq("halt_sticky_cnt", 32'(StallCnt), 4);
        idle_inputs();
        rst = 1'b0;
        #2 check_eq("async_rst_ctl", 32'(ctl), 32'(C_RST));
        check_eq("async_rst_trap", 32'(Trap), 0);
        check_eq("async_rst_cnt", 32'(StallCnt), 0);
        rst = 1'b1;
        #1 check_eq("async_init_ctl", 32'(ctl), 32'(C_INIT));
        cyc();
        check_eq("async_run_ctl", 32'(ctl), 32'(C_NORM));

        // Saturation of the 4-bit stall counter
        set_lu(5'd12);
        for (int i = 0; i < 20; i++) cyc();
        check_eq("sat_cnt", 32'(StallCnt), 15);
        check_eq("sat_ctl", 32'(ctl), 32'(C_LU));
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Produces the En/Clr pairs consumed by the IF/ID, ID/EX (data and control), EX/MEM and MEM/WB pipeline registers, plus the PC enable.
- Detects load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory waits.
- Sequences a post-reset pipeline flush, and provides a memory-timeout trap and a stall counter.

Parameters:
- REG_W, 5, register-specifier width.
- MEM_TIMEOUT, 255, max consecutive mem-wait cycles before trap (1..2^TO_W-1).
- TO_W, 8, timeout counter width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-low reset.
- ID_Rs  in  REG_W  rs of instruction in ID.
- ID_Rt  in  REG_W  rt of instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt.
- EX_Rt  in  REG_W  destination of instruction in EX.
- EX_ReadMem  in  1  EX instruction is a load.
- EX_WriteReg  in  1  EX instruction writes a register.
- MEM_Branch  in  1  branch in MEM.
- MEM_Zero  in  1  ALU zero for that branch.
- MEM_Req  in  1  MEM stage accessing data memory.
- MEM_Ready  in  1  data memory completes this cycle.
- PC_En  out  1  PC update enable.
- IFID_En  out  1  IF/ID enable.
- IFID_Clr  out  1  IF/ID clear.
- IDEX_En  out  1  ID/EX enable.
- IDEX_Clr  out  1  ID/EX clear.
- EXMEM_En  out  1  EX/MEM enable.
- EXMEM_Clr  out  1  EX/MEM clear.
- MEMWB_En  out  1  MEM/WB enable.
- MEMWB_Clr  out  1  MEM/WB clear.
- Trap  out  1  sticky memory-timeout flag.
- StallCnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- FSM states: INIT, RUN, MEM_WAIT, HALT. Asynchronous reset (rst=0) forces state=INIT, timeout counter=0, StallCnt=0, Trap=0.
- Outputs are combinational from state and inputs, i.e. Mealy, so they act on the current edge.
- While rst=0: all En=0, all Clr=1, PC_En=0.
- INIT (exactly one cycle after rst rises):
  - All Clr=1, all En=1, PC_En=0.
  - Next state is RUN.
- RUN outputs, in priority order:
  1. MEM wait (MEM_Req=1 and MEM_Ready=0): PC_En=IFID_En=IDEX_En=EXMEM_En=0, MEMWB_Clr=1. Next state is MEM_WAIT. Timeout counter loads 1.
  2. Taken branch (MEM_Branch and MEM_Zero): IFID_Clr=IDEX_Clr=EXMEM_Clr=1, PC_En=1 (PC loads target), MEMWB normal.
  3. Load-use: EX_ReadMem and EX_WriteReg and EX_Rt!=0, and (EX_Rt==ID_Rs or (ID_UsesRt and EX_Rt==ID_Rt)). Outputs: PC_En=0, IFID_En=0, IDEX_Clr=1, other stages normal.
  4. Otherwise: all En=1, all Clr=0.
- "Normal" means En=1, Clr=0.
- MEM_WAIT:
  - Outputs are identical to priority case 1 until MEM_Ready=1.
  - On MEM_Ready=1: all En=1, Clr=0 that cycle; return to RUN. A pending branch or load-use is not evaluated that cycle.
  - The timeout counter increments each cycle not ready. On reaching MEM_TIMEOUT with MEM_Ready=0: go to HALT and set Trap=1.
- HALT: all En=0, all Clr=0, PC_En=0. Remains until reset.
- StallCnt increments by 1 on every rising edge where PC_En=0 and state is RUN or MEM_WAIT. It saturates at all-ones and never wraps.
- A Clr=1 output always coexists with En=1 or is a don't-care for En. Downstream registers treat Clr as dominant.
- If rst is asserted mid-wait, the FSM aborts immediately with no pending state retained.

Decomposition:
- Shared package pipe_pkg:
  - FSM state encoding: INIT=2'd0, RUN=2'd1, MEM_WAIT=2'd2, HALT=2'd3.
  - REG_W constant.
  - Stage-control bundle ordering {PC, IFID, IDEX, EXMEM, MEMWB}.
- One natural sub-module: hazard_detect, the purely combinational load-use comparator. Outputs LoadUse. Instantiated once.
- The FSM, counters and output muxing remain in hazard_ctrl.

Test Plan:
- Reset release: after rst rises, one cycle with all Clr=1, PC_En=0. Next cycle all En=1, Clr=0. StallCnt=0, Trap=0.
- Load-use: EX_ReadMem=1, EX_WriteReg=1, EX_Rt=8, ID_Rs=8 gives PC_En=0, IFID_En=0, IDEX_Clr=1 for one cycle and StallCnt=1. Repeat with EX_Rt=0: no stall.
- Branch beats load-use: MEM_Branch=MEM_Zero=1 together with a load-use match gives IFID_Clr=IDEX_Clr=EXMEM_Clr=1, PC_En=1, no stall, StallCnt unchanged.
- Memory wait: MEM_Req=1 with MEM_Ready=0 for 3 cycles, then 1. Expect 3 frozen cycles with MEMWB_Clr=1, then a release cycle with all En=1. StallCnt=3.
- Timeout: MEM_TIMEOUT=4 and MEM_Ready held 0 gives HALT after 4 wait cycles, with Trap=1 and all En=0 sticky. An asynchronous rst pulse mid-HALT returns to INIT with Trap=0.
- Saturation: CNT_W=4 and 20 forced stalls leaves StallCnt=15.
